// File: rtl/rv32i_instr_gen_pkg.sv
// RV32I(M) encoding types shared by decode and the instruction generator.
package rv32im_types;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } instr_t;

    typedef enum logic [6:0] {
        OP_B_LUI    = 7'b0110111,
        OP_B_AUIPC  = 7'b0010111,
        OP_B_OP_IMM = 7'b0010011,
        OP_B_OP_REG = 7'b0110011
    } cp2_opcode;

    typedef enum logic [6:0] {
        F7_BASE      = 7'b0000000,
        F7_VARIANT   = 7'b0100000,
        F7_EXTENSION = 7'b0000001
    } funct7_t;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SR  = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        GEN,
        DONE
    } gen_state_t;

    typedef enum logic [2:0] {
        CLS_LUI,
        CLS_AUIPC,
        CLS_IMM_A,
        CLS_IMM_B,
        CLS_REG_A,
        CLS_REG_B,
        CLS_REG_C,
        CLS_MUL
    } gen_class_t;

    localparam logic [31:0] GEN_LFSR_TAPS = 32'h8020_0003;
    localparam logic [4:0]  PRIME_LAST    = 5'd31;

    function automatic logic [31:0] gen_lfsr_step(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? GEN_LFSR_TAPS : 32'h0);
    endfunction

endpackage

// File: rtl/rv32i_instr_gen_lfsr.sv
// 32-bit right-shifting Galois LFSR; steps only when advance is high.
module gen_lfsr
    import rv32im_types::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] seed,
    input  logic        advance,
    output logic [31:0] value
);

    logic [31:0] lfsr_q;
    logic [31:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (advance) lfsr_d = gen_lfsr_step(lfsr_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) lfsr_q <= seed;
        else        lfsr_q <= lfsr_d;
    end

    assign value = lfsr_q;

endmodule

// File: rtl/rv32i_instr_gen.sv
// LFSR-driven stream of legal lui/auipc/op_imm/op_reg words over valid/ready.
// Define RV32M_GEN_EN to turn class 7 into M-extension op_reg words.
module rv32i_instr_gen
    import rv32im_types::*;
#(
    parameter logic [31:0] SEED      = 32'hACE1_1234,
    parameter int unsigned NUM_INSTR = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_count,
    output logic        busy,
    output logic        done
);

    gen_state_t  state_q, state_d;
    logic [4:0]  prime_k_q, prime_k_d;
    logic [31:0] gen_cnt_q, gen_cnt_d;
    logic [31:0] count_q, count_d;
    logic        valid_q, valid_d;
    instr_t      instr_q, instr_d;
    logic [31:0] lfsr_val;
    logic [31:0] lfsr_adv;
    logic        hs;

    assign hs       = valid_q & instr_ready;
    assign lfsr_adv = gen_lfsr_step(lfsr_val);

    gen_lfsr u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .seed    (SEED),
        .advance (hs),
        .value   (lfsr_val)
    );

    // Priming words give every rd x1..x31 a defined value first.
    function automatic instr_t prime_word(
        input logic [19:0] upper,
        input logic [4:0]  k
    );
        return instr_t'({upper, k, OP_B_LUI});
    endfunction

    function automatic instr_t gen_word(input logic [31:0] l);
        instr_t     w;
        gen_class_t cls;
        logic [2:0] f3;
        logic       alt;
        logic [11:0] imm;
        funct7_t    f7;
        cls = gen_class_t'(l[2:0]);
        f3  = l[20:18];
        alt = l[21];
        imm = l[31:20];
        f7  = (alt && (f3 == F3_ADD || f3 == F3_SR)) ? F7_VARIANT : F7_BASE;
        if (f3 == F3_SLL) imm[11:5] = F7_BASE;
        if (f3 == F3_SR)  imm[11:5] = alt ? F7_VARIANT : F7_BASE;
        w = '{funct7: f7, rs2: l[17:13], rs1: l[12:8],
              funct3: f3, rd: l[7:3], opcode: OP_B_OP_REG};
        case (cls)
            CLS_LUI:   w = instr_t'({l[31:12], l[7:3], OP_B_LUI});
            CLS_AUIPC: w = instr_t'({l[31:12], l[7:3], OP_B_AUIPC});
            CLS_IMM_A,
            CLS_IMM_B: w = instr_t'({imm, l[12:8], f3, l[7:3], OP_B_OP_IMM});
`ifdef RV32M_GEN_EN
            CLS_MUL:   w.funct7 = F7_EXTENSION;
`endif
            default:   ;
        endcase
        return w;
    endfunction

    always_comb begin
        state_d   = state_q;
        prime_k_d = prime_k_q;
        gen_cnt_d = gen_cnt_q;
        count_d   = count_q;
        valid_d   = valid_q;
        instr_d   = instr_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = PRIME;
                    prime_k_d = 5'd1;
                    gen_cnt_d = 32'd0;
                    count_d   = 32'd0;
                    valid_d   = 1'b1;
                    instr_d   = prime_word(lfsr_val[31:12], 5'd1);
                end
            end
            PRIME: begin
                if (hs) begin
                    count_d = count_q + 32'd1;
                    if (prime_k_q == PRIME_LAST) begin
                        state_d   = GEN;
                        gen_cnt_d = 32'd0;
                        instr_d   = gen_word(lfsr_adv);
                    end else begin
                        prime_k_d = prime_k_q + 5'd1;
                        instr_d   = prime_word(lfsr_adv[31:12],
                                               prime_k_q + 5'd1);
                    end
                end
            end
            GEN: begin
                if (hs) begin
                    count_d = count_q + 32'd1;
                    // NUM_INSTR of zero means the stream never ends.
                    if (NUM_INSTR != 0 && gen_cnt_q == NUM_INSTR - 1) begin
                        state_d = DONE;
                        valid_d = 1'b0;
                    end else begin
                        gen_cnt_d = gen_cnt_q + 32'd1;
                        instr_d   = gen_word(lfsr_adv);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            prime_k_q <= 5'd1;
            gen_cnt_q <= 32'd0;
            count_q   <= 32'd0;
            valid_q   <= 1'b0;
            instr_q   <= '0;
        end else begin
            state_q   <= state_d;
            prime_k_q <= prime_k_d;
            gen_cnt_q <= gen_cnt_d;
            count_q   <= count_d;
            valid_q   <= valid_d;
            instr_q   <= instr_d;
        end
    end

    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign instr_count = count_q;
    assign busy        = (state_q == PRIME) || (state_q == GEN);
    assign done        = (state_q == DONE);

endmodule
